// File: rtl/main_fsm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : main_fsm_pkg                                              |
// | Brief    : Shared types and encodings for the multicycle RISC-V      |
// |            main control FSM. Optional macro: MAIN_FSM_JALR_EN        |
// |            (adds the JALRADR state).                                 |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package main_fsm_pkg;

    // Controller states, explicitly encoded in 4 bits
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
`ifdef MAIN_FSM_JALR_EN
        ,
        S_JALRADR  = 4'd11
`endif
    } state_t;

    // Opcode field values
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // ALUOp encodings consumed by the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Result multiplexer selects
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALU operand A selects
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU operand B selects
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Raw per-state control word, before reset / ready qualification
    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       reg_write;
        logic       mem_write;
        logic       ir_write;
        logic       adr_src;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/main_fsm_out.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : main_fsm_out                                              |
// | Brief    : Combinational decoder from controller state to raw        |
// |            datapath control word. Optional macro: MAIN_FSM_JALR_EN.  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module main_fsm_out
    import main_fsm_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    // Per-state control decode; unlisted fields stay at zero
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.ir_write   = 1'b1;
                ctrl.pc_update  = 1'b1;
                ctrl.adr_src    = 1'b0;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                // Precompute branch/jump target into ALUOut
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl.adr_src = 1'b1;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.adr_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXECR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.branch     = 1'b1;
            end
            S_JAL: begin
                // PC takes the target from ALUOut while ALU forms OldPC+4
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_update  = 1'b1;
            end
`ifdef MAIN_FSM_JALR_EN
            S_JALRADR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
`endif
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/main_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : main_fsm                                                  |
// | Brief    : Multicycle RISC-V main control FSM. Holds the state       |
// |            register and next-state logic, and qualifies the decoded  |
// |            enables with reset and the memory ready handshake.        |
// |            Optional macro: MAIN_FSM_JALR_EN (JALR support).          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module main_fsm
    import main_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       illegal_op
);

    state_t r_state;
    state_t w_next_state;
    logic   w_illegal;
    logic   w_fetch_gate;
    ctrl_t  w_ctrl;

    // State register; reset returns to FETCH immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; op is only looked at in DECODE and MEMADR
    always_comb begin
        w_next_state = r_state;
        w_illegal    = 1'b0;
        case (r_state)
            S_FETCH:    if (mem_ready) w_next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD,
                    OP_STORE:  w_next_state = S_MEMADR;
                    OP_R:      w_next_state = S_EXECR;
                    OP_I:      w_next_state = S_EXECI;
                    OP_BRANCH: w_next_state = S_BEQ;
                    OP_JAL:    w_next_state = S_JAL;
`ifdef MAIN_FSM_JALR_EN
                    OP_JALR:   w_next_state = S_JALRADR;
`endif
                    default: begin
                        w_next_state = S_FETCH;
                        w_illegal    = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   w_next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) w_next_state = S_MEMWB;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: if (mem_ready) w_next_state = S_FETCH;
            S_EXECR:    w_next_state = S_ALUWB;
            S_EXECI:    w_next_state = S_ALUWB;
            S_ALUWB:    w_next_state = S_FETCH;
            S_BEQ:      w_next_state = S_FETCH;
            S_JAL:      w_next_state = S_ALUWB;
`ifdef MAIN_FSM_JALR_EN
            S_JALRADR:  w_next_state = S_JAL;
`endif
            default:    w_next_state = S_FETCH;
        endcase
    end

    main_fsm_out u_out (
        .state (r_state),
        .ctrl  (w_ctrl)
    );

    // FETCH only commits the instruction once memory returns it
    assign w_fetch_gate = (r_state != S_FETCH) || mem_ready;

    // Enables are suppressed while reset is high; selects pass straight through
    always_comb begin
        PCUpdate   = !rst && w_ctrl.pc_update && w_fetch_gate;
        IRWrite    = !rst && w_ctrl.ir_write && w_fetch_gate;
        Branch     = !rst && w_ctrl.branch;
        RegWrite   = !rst && w_ctrl.reg_write;
        MemWrite   = !rst && w_ctrl.mem_write;
        illegal_op = !rst && w_illegal;
        AdrSrc     = w_ctrl.adr_src;
        ResultSrc  = w_ctrl.result_src;
        ALUSrcA    = w_ctrl.alu_src_a;
        ALUSrcB    = w_ctrl.alu_src_b;
        ALUOp      = w_ctrl.alu_op;
    end

endmodule
`default_nettype wire

// File: tb/tb_main_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_main_fsm                                               |
// | Brief    : Directed self-checking bench for main_fsm. Follows the    |
// |            MAIN_FSM_JALR_EN macro for the JALR sequence.             |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_main_fsm;

    logic       clk;
    logic       rst;
    logic [6:0] op;
    logic       mem_ready;
    logic       PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc, illegal_op;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [14:0] outs;

    int checks   = 0;
    int failures = 0;

    // Output word: PCU BR RW MW IR ADR RES[2] SA[2] SB[2] AOP[2] ILL
    localparam logic [14:0] V_RESET   = 15'b0_0_0_0_0_0_10_00_10_00_0;
    localparam logic [14:0] V_FETCH   = 15'b1_0_0_0_1_0_10_00_10_00_0;
    localparam logic [14:0] V_FWAIT   = 15'b0_0_0_0_0_0_10_00_10_00_0;
    localparam logic [14:0] V_DECODE  = 15'b0_0_0_0_0_0_00_01_01_00_0;
    localparam logic [14:0] V_DEC_ILL = 15'b0_0_0_0_0_0_00_01_01_00_1;
    localparam logic [14:0] V_MEMADR  = 15'b0_0_0_0_0_0_00_10_01_00_0;
    localparam logic [14:0] V_MEMREAD = 15'b0_0_0_0_0_1_00_00_00_00_0;
    localparam logic [14:0] V_MEMWB   = 15'b0_0_1_0_0_0_01_00_00_00_0;
    localparam logic [14:0] V_MEMWR   = 15'b0_0_0_1_0_1_00_00_00_00_0;
    localparam logic [14:0] V_EXECR   = 15'b0_0_0_0_0_0_00_10_00_10_0;
    localparam logic [14:0] V_EXECI   = 15'b0_0_0_0_0_0_00_10_01_10_0;
    localparam logic [14:0] V_ALUWB   = 15'b0_0_1_0_0_0_00_00_00_00_0;
    localparam logic [14:0] V_BEQ     = 15'b0_1_0_0_0_0_00_10_00_01_0;
    localparam logic [14:0] V_JAL     = 15'b1_0_0_0_0_0_00_01_10_00_0;
`ifdef MAIN_FSM_JALR_EN
    localparam logic [14:0] V_JALRADR = 15'b0_0_0_0_0_0_00_10_01_00_0;
`endif

    main_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .mem_ready  (mem_ready),
        .PCUpdate   (PCUpdate),
        .Branch     (Branch),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .illegal_op (illegal_op)
    );

    assign outs = {PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc,
                   ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal_op};

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Check one cycle's outputs at the falling edge, then advance past the next rising edge
    task automatic cyc(input logic [14:0] exp, input string tag);
        @(negedge clk);
        checks++;
        assert (outs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, outs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b1;
        op        = 7'b0;
        @(posedge clk);
        #1;

        // Reset held for three cycles with memory ready
        cyc(V_RESET, "reset0");
        cyc(V_RESET, "reset1");
        cyc(V_RESET, "reset2");
        rst = 1'b0;

        // R-type: FETCH DECODE EXECR ALUWB
        op = 7'b0110011;
        cyc(V_FETCH,  "r_fetch");
        cyc(V_DECODE, "r_decode");
        cyc(V_EXECR,  "r_execr");
        cyc(V_ALUWB,  "r_aluwb");

        // Load with one FETCH wait and two MEMREAD waits; op noise after MEMADR
        op = 7'b0000011;
        mem_ready = 1'b0;
        cyc(V_FWAIT,  "lw_fetch_wait");
        mem_ready = 1'b1;
        cyc(V_FETCH,  "lw_fetch");
        cyc(V_DECODE, "lw_decode");
        cyc(V_MEMADR, "lw_memadr");
        mem_ready = 1'b0;
        op = 7'b1111111;
        cyc(V_MEMREAD, "lw_memread_w0");
        op = 7'b0100011;
        cyc(V_MEMREAD, "lw_memread_w1");
        mem_ready = 1'b1;
        cyc(V_MEMREAD, "lw_memread");
        cyc(V_MEMWB,   "lw_memwb");

        // Store: MemWrite only in cycle 4
        op = 7'b0100011;
        cyc(V_FETCH,  "sw_fetch");
        cyc(V_DECODE, "sw_decode");
        cyc(V_MEMADR, "sw_memadr");
        cyc(V_MEMWR,  "sw_memwrite");

        // Branch: three cycles
        op = 7'b1100011;
        cyc(V_FETCH,  "beq_fetch");
        cyc(V_DECODE, "beq_decode");
        cyc(V_BEQ,    "beq_exec");

        // I-type
        op = 7'b0010011;
        cyc(V_FETCH,  "i_fetch");
        cyc(V_DECODE, "i_decode");
        cyc(V_EXECI,  "i_execi");
        cyc(V_ALUWB,  "i_aluwb");

        // JAL
        op = 7'b1101111;
        cyc(V_FETCH,  "jal_fetch");
        cyc(V_DECODE, "jal_decode");
        cyc(V_JAL,    "jal_jal");
        cyc(V_ALUWB,  "jal_aluwb");

        // Unsupported opcode: one-cycle pulse, straight back to FETCH
        op = 7'b1111111;
        cyc(V_FETCH,   "ill_fetch");
        cyc(V_DEC_ILL, "ill_decode");

        // JALR
        op = 7'b1100111;
        cyc(V_FETCH,   "jalr_fetch");
`ifdef MAIN_FSM_JALR_EN
        cyc(V_DECODE,  "jalr_decode");
        cyc(V_JALRADR, "jalr_adr");
        cyc(V_JAL,     "jalr_jal");
        cyc(V_ALUWB,   "jalr_aluwb");
`else
        cyc(V_DEC_ILL, "jalr_illegal");
`endif

        // Reset during EXECR aborts the instruction with no write
        op = 7'b0110011;
        cyc(V_FETCH,  "abort_fetch");
        cyc(V_DECODE, "abort_decode");
        rst = 1'b1;
        cyc(V_RESET,  "abort_reset");
        rst = 1'b0;
        cyc(V_FETCH,  "abort_refetch");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
